dmem_arbiter: RTL and testbench

Two-port arbiter and stall controller in front of the single-ported `dataMemory`. It shares the memory between the RISC-V `core`, which issues LW/SW, and a DMA/debug loader port. The core normally has priority, but a bounded starvation counter forces DMA slots and can lock the memory for short DMA bursts. It sits inside `risc_v` between `core`, `dataMemory` and the loader, and drives a stall that the core uses to freeze its PC and suppress its register-file write.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/sat_counter.sv | 44 ++++
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_e      : arbiter FSM state encoding
//   DEF_MAX_CORE_RUN : default number of core grants allowed while DMA waits
//   DEF_MAX_LOCK     : default maximum length of a locked DMA burst
//   cnt_width()      : register width needed to count 0..max inclusive
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        CORE_PRI  = 2'd0,
        DMA_FORCE = 2'd1,
        DMA_LOCK  = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_MAX_CORE_RUN = 4;
    localparam int unsigned DEF_MAX_LOCK     = 8;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i   : clock, state changes on posedge
//   rst_i   : synchronous active-high reset, count returns to 0
//   clr_i   : synchronous clear, takes priority over inc_i
//   inc_i   : increment request, ignored once count reaches MAX
//   count_o : current count (0..MAX)
module sat_counter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX   = 4,
    parameter int unsigned WIDTH = cnt_width(MAX)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q < MAX_VAL)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and stall controller in front of the single-ported data
// memory. The core has priority; a starvation counter forces DMA slots and a
// DMA port may lock the memory for short bursts.
//   clock, reset                    : clock and synchronous active-high reset
//   core_req/we/addr/wdata          : core LW/SW access
//   core_rdata, core_stall          : load data (combinational) and stall
//   dma_req/we/addr/wdata, dma_lock : DMA/loader command and burst lock
//   dma_gnt                         : DMA access performed this cycle
//   dma_rdata, dma_rvalid           : registered DMA read data and its pulse
//   mem_we/addr/wdata, mem_rdata    : single-ported data memory interface
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_CORE_RUN = DEF_MAX_CORE_RUN,
    parameter int unsigned MAX_LOCK     = DEF_MAX_LOCK
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_lock,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned      RUN_W        = cnt_width(MAX_CORE_RUN);
    localparam int unsigned      LOCK_W       = cnt_width(MAX_LOCK);
    localparam logic [RUN_W-1:0] RUN_LAST     = RUN_W'(MAX_CORE_RUN - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST   = LOCK_W'(MAX_LOCK - 1);
    localparam bit               LOCK_ALLOWED = (MAX_LOCK > 1);

    arb_state_e        state_q;
    logic [RUN_W-1:0]  run_cnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic              core_gnt;
    logic              dma_gnt_w;
    logic              run_inc;
    logic              lock_inc;
    logic              dma_rd_w;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              dma_rvalid_q;

    // Grants are combinational so an uncontended LW/SW completes in one cycle.
    // Reset suppresses every grant, so no write can commit in the reset cycle.
    always_comb begin
        core_gnt  = 1'b0;
        dma_gnt_w = 1'b0;
        if (!reset) begin
            if (state_q == CORE_PRI) begin
                core_gnt  = core_req;
                dma_gnt_w = dma_req & ~core_req;
            end else begin
                dma_gnt_w = dma_req;
                core_gnt  = core_req & ~dma_req;
            end
        end
    end

    // Starvation count advances only while DMA waits behind a core grant;
    // any other cycle clears it.
    assign run_inc = (state_q == CORE_PRI) & core_gnt & dma_req;

    // lock_cnt counts the grants of the current burst, the entry grant
    // included, so a burst ends on its MAX_LOCK-th grant. It is zero in every
    // state other than DMA_LOCK, so the entry increment lands on 1.
    assign lock_inc = dma_gnt_w & dma_lock &
                      ((state_q == DMA_LOCK) ? (lock_cnt < LOCK_LAST) : LOCK_ALLOWED);

    sat_counter #(
        .MAX   (MAX_CORE_RUN),
        .WIDTH (RUN_W)
    ) u_run_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .clr_i   (~run_inc),
        .inc_i   (run_inc),
        .count_o (run_cnt)
    );

    sat_counter #(
        .MAX   (MAX_LOCK),
        .WIDTH (LOCK_W)
    ) u_lock_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .clr_i   (~lock_inc),
        .inc_i   (lock_inc),
        .count_o (lock_cnt)
    );

    assign dma_rd_w = dma_gnt_w & ~dma_we;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= CORE_PRI;
            dma_rdata_q  <= '0;
            dma_rvalid_q <= 1'b0;
        end else begin
            if (lock_inc) begin
                state_q <= DMA_LOCK;
            end else if (run_inc && (run_cnt == RUN_LAST)) begin
                state_q <= DMA_FORCE;
            end else begin
                state_q <= CORE_PRI;
            end
            dma_rvalid_q <= dma_rd_w;
            if (dma_rd_w) begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_we     = dma_gnt_w ? dma_we    : (core_gnt & core_we);
    assign mem_addr   = dma_gnt_w ? dma_addr  : core_addr;
    assign mem_wdata  = dma_gnt_w ? dma_wdata : core_wdata;

    assign core_rdata = mem_rdata;
    assign core_stall = core_req & ~core_gnt & ~reset;
    assign dma_gnt    = dma_gnt_w;
    assign dma_rdata  = dma_rdata_q;
    assign dma_rvalid = dma_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        core_req;
    logic        core_we;
    logic [5:0]  core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        dma_req;
    logic        dma_we;
    logic [5:0]  dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_lock;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    // Word-addressed data memory, word 4 (byte 0x10) preloaded.
    logic [31:0] mem [16] = '{4: 32'h0000A018, default: 32'h0};

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
    end

    assign mem_rdata = mem[mem_addr[5:2]];

    dmem_arbiter #(
        .ADDR_W       (6),
        .DATA_W       (32),
        .MAX_CORE_RUN (4),
        .MAX_LOCK     (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_lock   (dma_lock),
        .dma_gnt    (dma_gnt),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        rst;
        logic        creq;
        logic        cwe;
        logic [5:0]  caddr;
        logic [31:0] cwd;
        logic        dreq;
        logic        dwe;
        logic        dlock;
        logic [5:0]  daddr;
        logic [31:0] dwd;
        logic        e_stall;
        logic        e_dgnt;
        logic        e_mwe;
        logic [5:0]  e_maddr;
        logic        crd_chk;
        logic [31:0] e_crd;
        logic        e_rv;
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic creq, input logic cwe,
        input logic [5:0] caddr, input logic [31:0] cwd,
        input logic dreq, input logic dwe, input logic dlock,
        input logic [5:0] daddr, input logic [31:0] dwd,
        input logic st, input logic dg, input logic mw, input logic [5:0] ma,
        input logic crc, input logic [31:0] crd,
        input logic rv, input logic [31:0] rd);
        vec_t v;
        v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.dlock = dlock; v.daddr = daddr; v.dwd = dwd;
        v.e_stall = st; v.e_dgnt = dg; v.e_mwe = mw; v.e_maddr = ma;
        v.crd_chk = crc; v.e_crd = crd; v.e_rv = rv; v.e_rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clock);
        reset      = v.rst;
        core_req   = v.creq;
        core_we    = v.cwe;
        core_addr  = v.caddr;
        core_wdata = v.cwd;
        dma_req    = v.dreq;
        dma_we     = v.dwe;
        dma_lock   = v.dlock;
        dma_addr   = v.daddr;
        dma_wdata  = v.dwd;
        #1;
    endtask

    vec_t tbl [19];
    vec_t v;
    int   k;
    logic exp_g;

    initial begin
        // rst creq cwe caddr cwd | dreq dwe dlock daddr dwd || stall dgnt mwe maddr crchk crd rv rd
        // Reset with both ports requesting writes: nothing granted.
        tbl[0]  = mk(1,1,1,6'h08,32'h3C, 1,1,0,6'h14,32'h77, 0,0,0,6'h08, 0,0,      0,0);
        tbl[1]  = mk(1,0,0,6'h00,32'h0,  0,0,0,6'h00,32'h0,  0,0,0,6'h00, 0,0,      0,0);
        // Uncontended SW then LW.
        tbl[2]  = mk(0,1,1,6'h08,32'h3C, 0,0,0,6'h00,32'h0,  0,0,1,6'h08, 0,0,      0,0);
        tbl[3]  = mk(0,1,0,6'h08,32'h0,  0,0,0,6'h00,32'h0,  0,0,0,6'h08, 1,32'h3C, 0,0);
        // DMA read alone, data one cycle later for one cycle.
        tbl[4]  = mk(0,0,0,6'h00,32'h0,  1,0,0,6'h10,32'h0,  0,1,0,6'h10, 1,32'hA018, 0,0);
        tbl[5]  = mk(0,0,0,6'h00,32'h0,  0,0,0,6'h00,32'h0,  0,0,0,6'h00, 0,0,      1,32'hA018);
        tbl[6]  = mk(0,0,0,6'h00,32'h0,  0,0,0,6'h00,32'h0,  0,0,0,6'h00, 0,0,      0,0);
        // Starvation: four core grants, one forced DMA write, core again.
        tbl[7]  = mk(0,1,0,6'h08,32'h0,  1,1,0,6'h14,32'h55, 0,0,0,6'h08, 1,32'h3C, 0,0);
        tbl[8]  = tbl[7];
        tbl[9]  = tbl[7];
        tbl[10] = tbl[7];
        tbl[11] = mk(0,1,0,6'h08,32'h0,  1,1,0,6'h14,32'h55, 1,1,1,6'h14, 1,32'h0,  0,0);
        tbl[12] = tbl[7];
        tbl[13] = tbl[7];
        tbl[14] = tbl[7];
        tbl[15] = tbl[7];
        // Forced slot reached but DMA drops: core gets the cycle.
        tbl[16] = mk(0,1,0,6'h08,32'h0,  0,1,0,6'h14,32'h55, 0,0,0,6'h08, 1,32'h3C, 0,0);
        // Back in core priority: contended cycle goes to the core.
        tbl[17] = tbl[7];
        // Forced write landed.
        tbl[18] = mk(0,1,0,6'h14,32'h0,  0,0,0,6'h00,32'h0,  0,0,0,6'h14, 1,32'h55, 0,0);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i]);
            chk($sformatf("row%0d core_stall", i), 32'(core_stall), 32'(tbl[i].e_stall));
            chk($sformatf("row%0d dma_gnt", i),    32'(dma_gnt),    32'(tbl[i].e_dgnt));
            chk($sformatf("row%0d mem_we", i),     32'(mem_we),     32'(tbl[i].e_mwe));
            chk($sformatf("row%0d mem_addr", i),   32'(mem_addr),   32'(tbl[i].e_maddr));
            chk($sformatf("row%0d dma_rvalid", i), 32'(dma_rvalid), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv)
                chk($sformatf("row%0d dma_rdata", i), dma_rdata, tbl[i].e_rd);
            if (tbl[i].crd_chk)
                chk($sformatf("row%0d core_rdata", i), core_rdata, tbl[i].e_crd);
        end

        // Lock burst: DMA writes k to word k+4 for k=1..9 while the core keeps
        // reading. Expected: 4 core, 8 DMA, 4 core, forced 9th DMA write.
        k = 1;
        for (int c = 0; c < 17; c++) begin
            v = mk(0,1,0,6'h3C,32'h0, (k <= 9),1,1,6'((k + 4) * 4),32'(k),
                   0,0,0,6'h00, 0,0, 0,0);
            drive(v);
            exp_g = ((c >= 4) && (c <= 11)) || (c == 16);
            chk($sformatf("lock c%0d dma_gnt", c),    32'(dma_gnt),    32'(exp_g));
            chk($sformatf("lock c%0d core_stall", c), 32'(core_stall), 32'(exp_g));
            if (dma_gnt) k++;
        end
        drive(mk(0,0,0,6'h00,32'h0, 0,0,0,6'h00,32'h0, 0,0,0,6'h00, 0,0, 0,0));
        chk("lock writes granted", 32'(k), 32'd10);
        for (int w = 1; w <= 9; w++)
            chk($sformatf("lock mem word%0d", w + 4), mem[w + 4], 32'(w));

        // Reset in the middle of a locked burst.
        drive(mk(0,0,0,6'h00,32'h0, 1,0,1,6'h10,32'h0, 0,0,0,6'h00, 0,0, 0,0));
        chk("rstlock entry dma_gnt", 32'(dma_gnt), 32'd1);
        drive(mk(1,1,1,6'h3C,32'hBAD, 1,1,1,6'h38,32'hDEAD, 0,0,0,6'h00, 0,0, 0,0));
        chk("rstlock mem_we",     32'(mem_we),     32'd0);
        chk("rstlock dma_gnt",    32'(dma_gnt),    32'd0);
        chk("rstlock core_stall", 32'(core_stall), 32'd0);
        chk("rstlock prior rvalid", 32'(dma_rvalid), 32'd1);
        chk("rstlock prior rdata",  dma_rdata,       32'hA018);
        drive(mk(0,1,0,6'h38,32'h0, 0,0,0,6'h00,32'h0, 0,0,0,6'h00, 0,0, 0,0));
        chk("post-rst dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("post-rst core_stall", 32'(core_stall), 32'd0);
        chk("post-rst word14",     core_rdata,      32'h0);
        drive(mk(0,1,0,6'h3C,32'h0, 1,1,0,6'h38,32'hDEAD, 0,0,0,6'h00, 0,0, 0,0));
        chk("post-rst core_pri dma_gnt",    32'(dma_gnt),    32'd0);
        chk("post-rst core_pri core_stall", 32'(core_stall), 32'd0);
        chk("post-rst word15",              core_rdata,      32'h0);
        drive(mk(0,0,0,6'h00,32'h0, 0,0,0,6'h00,32'h0, 0,0,0,6'h00, 0,0, 0,0));
        chk("mem word14 untouched", mem[14], 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
